// File: rtl/fb_fill_pkg.sv
// Shared types and constants for the framebuffer fill arbiter.
// Holds the FSM state encoding, the register indices and the CTRL/STATUS bit positions.
package fb_fill_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   localparam logic [1:0] REG_BASE  = 2'd0;
   localparam logic [1:0] REG_COUNT = 2'd1;
   localparam logic [1:0] REG_VALUE = 2'd2;
   localparam logic [1:0] REG_CTRL  = 2'd3;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_CLEAR = 2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;

endpackage

// File: rtl/fb_fill_regs.sv
// Fill-engine register file: BASE/COUNT/VALUE storage, the VALUE shadow copy,
// CTRL strobe decode and the one-cycle CPU read-data path.
module fb_fill_regs
   import fb_fill_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 13,
   parameter int CNT_WIDTH     = ADDRESS_WIDTH + 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     reg_wr,
   input  logic                     reg_rd,
   input  logic [1:0]               reg_idx,
   input  logic [31:0]              reg_wdata,
   input  logic                     latch_shadow,
   input  logic [CNT_WIDTH-1:0]     remaining,
   input  logic                     busy,
   input  logic                     done_sticky,
   input  logic [31:0]              ram_data_read,
   output logic [ADDRESS_WIDTH-1:0] base_q,
   output logic [CNT_WIDTH-1:0]     count_q,
   output logic [31:0]              shadow_value,
   output logic                     start_req,
   output logic                     abort_req,
   output logic                     clear_req,
   output logic [31:0]              data_read
);

   logic [31:0] value_q;
   logic [31:0] reg_rdata_q;
   logic        sel_q;
   logic [31:0] reg_rdata_n;
   logic        ctrl_wr;

   assign ctrl_wr   = reg_wr && (reg_idx == REG_CTRL);
   assign start_req = ctrl_wr && reg_wdata[CTRL_START];
   assign abort_req = ctrl_wr && reg_wdata[CTRL_ABORT];
   assign clear_req = ctrl_wr && reg_wdata[CTRL_CLEAR];

   // COUNT reads back the engine's live remaining count, not the written value.
   always_comb begin
      reg_rdata_n = 32'd0;
      case (reg_idx)
         REG_BASE:  reg_rdata_n = 32'(base_q);
         REG_COUNT: reg_rdata_n = 32'(remaining);
         REG_VALUE: reg_rdata_n = value_q;
         default: begin
            reg_rdata_n[STAT_BUSY] = busy;
            reg_rdata_n[STAT_DONE] = done_sticky;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         base_q       <= '0;
         count_q      <= '0;
         value_q      <= '0;
         shadow_value <= '0;
         reg_rdata_q  <= '0;
         sel_q        <= 1'b0;
      end else begin
         if (reg_wr) begin
            case (reg_idx)
               REG_BASE:  base_q  <= reg_wdata[ADDRESS_WIDTH-1:0];
               REG_COUNT: count_q <= reg_wdata[CNT_WIDTH-1:0];
               REG_VALUE: value_q <= reg_wdata;
               default:   ;
            endcase
         end
         if (latch_shadow) begin
            shadow_value <= value_q;
         end
         if (reg_rd) begin
            reg_rdata_q <= reg_rdata_n;
         end
         sel_q <= reg_rd;
      end
   end

   assign data_read = sel_q ? reg_rdata_q : ram_data_read;

endmodule

// File: rtl/fb_fill_arbiter.sv
// Arbitrates framebuffer RAM port 1 between DLX CPU accesses and a constant-word
// fill engine; the CPU always wins and the engine simply stalls on CPU RAM cycles.
//
// state | meaning
// IDLE  | engine stopped; RAM port follows the CPU only
// FILL  | engine writes shadow_value at cur_addr on every non-CPU cycle
module fb_fill_arbiter
   import fb_fill_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 13,
   parameter int CNT_WIDTH     = ADDRESS_WIDTH + 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     DLX_enable,
   input  logic [31:0]              DLX_address,
   input  logic [31:0]              DLX_data_write,
   input  logic                     DLX_write_enable,
   output logic [31:0]              DLX_data_read,
   output logic [ADDRESS_WIDTH-1:0] ram_address,
   output logic [31:0]              ram_data_write,
   output logic                     ram_write_enable,
   input  logic [31:0]              ram_data_read,
   output logic                     fill_busy,
   output logic                     fill_done
);

   fill_state_t state_q, state_n;

   logic [ADDRESS_WIDTH-1:0] cur_addr_q;
   logic [CNT_WIDTH-1:0]     remaining_q;
   logic                     done_q;
   logic                     done_sticky_q;

   logic                     cpu_ram;
   logic                     reg_wr;
   logic                     reg_rd;
   logic                     slot;
   logic                     done_set;
   logic                     latch_shadow;

   logic [ADDRESS_WIDTH-1:0] base_q;
   logic [CNT_WIDTH-1:0]     count_q;
   logic [31:0]              shadow_value;
   logic                     start_req;
   logic                     abort_req;
   logic                     clear_req;

   logic                     unused_addr_hi;

   assign unused_addr_hi = ^DLX_address[31:ADDRESS_WIDTH+1];

   assign cpu_ram = DLX_enable && !DLX_address[ADDRESS_WIDTH];
   assign reg_wr  = DLX_enable && DLX_address[ADDRESS_WIDTH] && DLX_write_enable;
   assign reg_rd  = DLX_enable && DLX_address[ADDRESS_WIDTH] && !DLX_write_enable;

   fb_fill_regs #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .CNT_WIDTH     (CNT_WIDTH)
   ) u_regs (
      .clk           (clk),
      .reset_n       (reset_n),
      .reg_wr        (reg_wr),
      .reg_rd        (reg_rd),
      .reg_idx       (DLX_address[1:0]),
      .reg_wdata     (DLX_data_write),
      .latch_shadow  (latch_shadow),
      .remaining     (remaining_q),
      .busy          (fill_busy),
      .done_sticky   (done_sticky_q),
      .ram_data_read (ram_data_read),
      .base_q        (base_q),
      .count_q       (count_q),
      .shadow_value  (shadow_value),
      .start_req     (start_req),
      .abort_req     (abort_req),
      .clear_req     (clear_req),
      .data_read     (DLX_data_read)
   );

   // The abort cycle is a register access, yet it must not consume a write slot.
   always_comb begin
      state_n      = state_q;
      slot         = 1'b0;
      done_set     = 1'b0;
      latch_shadow = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_req && !abort_req) begin
               if (count_q != '0) begin
                  latch_shadow = 1'b1;
                  state_n      = FILL;
               end else begin
                  done_set = 1'b1;
               end
            end
         end
         FILL: begin
            if (abort_req) begin
               state_n  = IDLE;
               done_set = 1'b1;
            end else if (!cpu_ram) begin
               slot = 1'b1;
               if (remaining_q == CNT_WIDTH'(1)) begin
                  state_n  = IDLE;
                  done_set = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cur_addr_q    <= '0;
         remaining_q   <= '0;
         done_q        <= 1'b0;
         done_sticky_q <= 1'b0;
      end else begin
         state_q <= state_n;
         done_q  <= done_set;
         if (latch_shadow) begin
            cur_addr_q  <= base_q;
            remaining_q <= count_q;
         end else if (slot) begin
            cur_addr_q  <= cur_addr_q + ADDRESS_WIDTH'(1);
            remaining_q <= remaining_q - CNT_WIDTH'(1);
         end
         if (done_set) begin
            done_sticky_q <= 1'b1;
         end else if (clear_req || latch_shadow) begin
            done_sticky_q <= 1'b0;
         end
      end
   end

   always_comb begin
      ram_address      = cur_addr_q;
      ram_data_write   = shadow_value;
      ram_write_enable = 1'b0;
      if (cpu_ram) begin
         ram_address      = DLX_address[ADDRESS_WIDTH-1:0];
         ram_data_write   = DLX_data_write;
         ram_write_enable = DLX_write_enable;
      end else if (slot) begin
         ram_write_enable = 1'b1;
      end
      if (!reset_n) begin
         ram_write_enable = 1'b0;
      end
   end

   assign fill_busy = (state_q == FILL);
   assign fill_done = done_q;

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Directed bench for fb_fill_arbiter with a behavioural synchronous RAM on port 1.
module tb_fb_fill_arbiter;

   localparam int AW = 13;
   localparam logic [31:0] REG_SEL = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        DLX_enable;
   logic [31:0] DLX_address;
   logic [31:0] DLX_data_write;
   logic        DLX_write_enable;
   logic [31:0] DLX_data_read;
   logic [AW-1:0] ram_address;
   logic [31:0] ram_data_write;
   logic        ram_write_enable;
   logic [31:0] ram_data_read;
   logic        fill_busy;
   logic        fill_done;

   logic [31:0] mem [0:(1<<AW)-1];

   int n_pass  = 0;
   int n_total = 0;

   fb_fill_arbiter #(.ADDRESS_WIDTH(AW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .DLX_enable       (DLX_enable),
      .DLX_address      (DLX_address),
      .DLX_data_write   (DLX_data_write),
      .DLX_write_enable (DLX_write_enable),
      .DLX_data_read    (DLX_data_read),
      .ram_address      (ram_address),
      .ram_data_write   (ram_data_write),
      .ram_write_enable (ram_write_enable),
      .ram_data_read    (ram_data_read),
      .fill_busy        (fill_busy),
      .fill_done        (fill_done)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_address] <= ram_data_write;
      ram_data_read <= mem[ram_address];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      DLX_enable       = 1'b0;
      DLX_write_enable = 1'b0;
      DLX_address      = 32'd0;
      DLX_data_write   = 32'd0;
   endtask

   task automatic reg_write(input logic [1:0] idx, input logic [31:0] val);
      DLX_enable       = 1'b1;
      DLX_write_enable = 1'b1;
      DLX_address      = REG_SEL | 32'(idx);
      DLX_data_write   = val;
      tick();
      idle_bus();
      #1;
   endtask

   task automatic reg_read(input logic [1:0] idx, output logic [31:0] v);
      DLX_enable       = 1'b1;
      DLX_write_enable = 1'b0;
      DLX_address      = REG_SEL | 32'(idx);
      tick();
      idle_bus();
      #1;
      v = DLX_data_read;
   endtask

   task automatic ram_read(input logic [31:0] a, output logic [31:0] v);
      DLX_enable       = 1'b1;
      DLX_write_enable = 1'b0;
      DLX_address      = a;
      tick();
      idle_bus();
      #1;
      v = DLX_data_read;
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (fill_busy && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic start_fill(input logic [31:0] base, input logic [31:0] cnt, input logic [31:0] val);
      reg_write(2'd0, base);
      reg_write(2'd1, cnt);
      reg_write(2'd2, val);
      reg_write(2'd3, 32'h1);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      n_total++;
      if (fill_busy !== 1'b0 || fill_done !== 1'b0 || ram_write_enable !== 1'b0)
         $display("FAIL reset_outputs busy=%b done=%b we=%b want 0 0 0", fill_busy, fill_done, ram_write_enable);
      else n_pass++;
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         reg_read(2'(i), v);
         n_total++;
         if (v !== 32'd0) $display("FAIL reset_reg%0d got %h want 0", i, v);
         else n_pass++;
      end
   endtask

   task automatic test_basic();
      logic [31:0] v;
      start_fill(32'h100, 32'd4, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (fill_busy !== 1'b1 || ram_write_enable !== 1'b1 || fill_done !== 1'b0 ||
             ram_address !== AW'(32'h100 + i) || ram_data_write !== 32'hDEADBEEF)
            $display("FAIL basic_slot%0d busy=%b we=%b done=%b addr=%h data=%h want 1 1 0 %h deadbeef",
                     i, fill_busy, ram_write_enable, fill_done, ram_address, ram_data_write, 32'h100 + i);
         else n_pass++;
         tick();
      end
      n_total++;
      if (fill_busy !== 1'b0 || fill_done !== 1'b1)
         $display("FAIL basic_end busy=%b done=%b want 0 1", fill_busy, fill_done);
      else n_pass++;
      tick();
      n_total++;
      if (fill_done !== 1'b0) $display("FAIL basic_done_pulse done=%b want 0", fill_done);
      else n_pass++;
      ram_read(32'h102, v);
      n_total++;
      if (v !== 32'hDEADBEEF) $display("FAIL basic_read got %h want deadbeef", v);
      else n_pass++;
      ram_read(32'h104, v);
      n_total++;
      if (v !== 32'd0) $display("FAIL basic_past_end got %h want 0", v);
      else n_pass++;
      reg_read(2'd3, v);
      n_total++;
      if (v !== 32'h2) $display("FAIL basic_status got %h want 2", v);
      else n_pass++;
   endtask

   task automatic test_cpu_priority();
      logic [31:0] v;
      int cyc   = 0;
      int slots = 0;
      start_fill(32'h200, 32'd8, 32'hA5A5A5A5);
      while (fill_busy && cyc < 20) begin
         if (cyc >= 2 && cyc <= 4) begin
            DLX_enable = 1'b1; DLX_write_enable = 1'b1;
            DLX_address = 32'h500; DLX_data_write = 32'h55;
            #1;
            n_total++;
            if (ram_write_enable !== 1'b1 || ram_address !== AW'(32'h500) || ram_data_write !== 32'h55)
               $display("FAIL prio_cpu%0d we=%b addr=%h data=%h want 1 0500 55", cyc, ram_write_enable, ram_address, ram_data_write);
            else n_pass++;
         end else begin
            idle_bus();
            #1;
            n_total++;
            if (ram_write_enable !== 1'b1 || ram_address !== AW'(32'h200 + slots))
               $display("FAIL prio_slot%0d we=%b addr=%h want 1 %h", cyc, ram_write_enable, ram_address, 32'h200 + slots);
            else n_pass++;
            slots++;
         end
         tick();
         cyc++;
      end
      idle_bus();
      n_total++;
      if (cyc !== 11 || fill_done !== 1'b1)
         $display("FAIL prio_cycles got %0d done=%b want 11 1", cyc, fill_done);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         ram_read(32'h200 + i, v);
         n_total++;
         if (v !== 32'hA5A5A5A5) $display("FAIL prio_fill%0d got %h want a5a5a5a5", i, v);
         else n_pass++;
      end
      ram_read(32'h500, v);
      n_total++;
      if (v !== 32'h55) $display("FAIL prio_cpu_data got %h want 55", v);
      else n_pass++;
   endtask

   task automatic test_wrap_zero();
      logic [31:0] v;
      logic [AW-1:0] exp_a [4];
      exp_a[0] = 13'h1FFE; exp_a[1] = 13'h1FFF; exp_a[2] = 13'h0000; exp_a[3] = 13'h0001;
      start_fill(32'h1FFE, 32'd4, 32'h12345678);
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (ram_write_enable !== 1'b1 || ram_address !== exp_a[i])
            $display("FAIL wrap_slot%0d we=%b addr=%h want 1 %h", i, ram_write_enable, ram_address, exp_a[i]);
         else n_pass++;
         tick();
      end
      ram_read(32'h1, v);
      n_total++;
      if (v !== 32'h12345678) $display("FAIL wrap_read got %h want 12345678", v);
      else n_pass++;
      ram_read(32'h2, v);
      n_total++;
      if (v !== 32'd0) $display("FAIL wrap_past_end got %h want 0", v);
      else n_pass++;
      reg_write(2'd3, 32'h4);
      reg_read(2'd3, v);
      n_total++;
      if (v !== 32'h0) $display("FAIL clear_done got %h want 0", v);
      else n_pass++;
      reg_write(2'd1, 32'd0);
      DLX_enable = 1'b1; DLX_write_enable = 1'b1;
      DLX_address = REG_SEL | 32'd3; DLX_data_write = 32'h1;
      tick();
      idle_bus();
      #1;
      n_total++;
      if (fill_done !== 1'b1 || fill_busy !== 1'b0 || ram_write_enable !== 1'b0)
         $display("FAIL zero_start done=%b busy=%b we=%b want 1 0 0", fill_done, fill_busy, ram_write_enable);
      else n_pass++;
      tick();
      n_total++;
      if (fill_done !== 1'b0) $display("FAIL zero_pulse done=%b want 0", fill_done);
      else n_pass++;
      reg_read(2'd3, v);
      n_total++;
      if (v !== 32'h2) $display("FAIL zero_status got %h want 2", v);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic [31:0] v;
      int n;
      start_fill(32'h300, 32'd100, 32'h77);
      repeat (10) tick();
      DLX_enable = 1'b1; DLX_write_enable = 1'b1;
      DLX_address = REG_SEL | 32'd3; DLX_data_write = 32'h2;
      #1;
      n_total++;
      if (ram_write_enable !== 1'b0) $display("FAIL abort_no_slot we=%b want 0", ram_write_enable);
      else n_pass++;
      tick();
      idle_bus();
      #1;
      n_total++;
      if (fill_busy !== 1'b0 || fill_done !== 1'b1)
         $display("FAIL abort_stop busy=%b done=%b want 0 1", fill_busy, fill_done);
      else n_pass++;
      reg_read(2'd1, v);
      n_total++;
      if (v !== 32'd90) $display("FAIL abort_count got %0d want 90", v);
      else n_pass++;
      ram_read(32'h30A, v);
      n_total++;
      if (v !== 32'd0) $display("FAIL abort_untouched got %h want 0", v);
      else n_pass++;
      ram_read(32'h309, v);
      n_total++;
      if (v !== 32'h77) $display("FAIL abort_last got %h want 77", v);
      else n_pass++;
      start_fill(32'h400, 32'd6, 32'h99);
      tick();
      reg_write(2'd0, 32'h600);
      reg_write(2'd3, 32'h1);
      n_total++;
      if (fill_busy !== 1'b1 || ram_address !== AW'(32'h403))
         $display("FAIL restart_ignored busy=%b addr=%h want 1 0403", fill_busy, ram_address);
      else n_pass++;
      wait_idle(10, n);
      n_total++;
      if (n !== 3) $display("FAIL restart_tail got %0d cycles want 3", n);
      else n_pass++;
      ram_read(32'h600, v);
      n_total++;
      if (v !== 32'd0) $display("FAIL restart_base got %h want 0", v);
      else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      logic [31:0] v;
      start_fill(32'h700, 32'd20, 32'hCC);
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      n_total++;
      if (ram_write_enable !== 1'b0) $display("FAIL rst_we we=%b want 0", ram_write_enable);
      else n_pass++;
      tick();
      n_total++;
      if (fill_busy !== 1'b0 || fill_done !== 1'b0)
         $display("FAIL rst_state busy=%b done=%b want 0 0", fill_busy, fill_done);
      else n_pass++;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (fill_done !== 1'b0 || fill_busy !== 1'b0)
            $display("FAIL rst_after%0d done=%b busy=%b want 0 0", i, fill_done, fill_busy);
         else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
         reg_read(2'(i), v);
         n_total++;
         if (v !== 32'd0) $display("FAIL rst_reg%0d got %h want 0", i, v);
         else n_pass++;
      end
      ram_read(32'h703, v);
      n_total++;
      if (v !== 32'd0) $display("FAIL rst_no_write got %h want 0", v);
      else n_pass++;
   endtask

   task automatic test_shadow();
      logic [31:0] v;
      int n;
      start_fill(32'h800, 32'd6, 32'hAAAA0000);
      repeat (2) tick();
      reg_write(2'd2, 32'h1);
      wait_idle(20, n);
      n_total++;
      if (fill_busy !== 1'b0) $display("FAIL shadow_timeout busy=%b want 0", fill_busy);
      else n_pass++;
      ram_read(32'h805, v);
      n_total++;
      if (v !== 32'hAAAA0000) $display("FAIL shadow_keep got %h want aaaa0000", v);
      else n_pass++;
      reg_write(2'd0, 32'h900);
      reg_write(2'd1, 32'd2);
      reg_write(2'd3, 32'h1);
      wait_idle(20, n);
      ram_read(32'h901, v);
      n_total++;
      if (v !== 32'h1) $display("FAIL shadow_next got %h want 1", v);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
      reset_n = 1'b0;
      idle_bus();
      tick();
      tick();
      test_reset();
      test_basic();
      test_cpu_priority();
      test_wrap_zero();
      test_abort();
      test_reset_mid_fill();
      test_shadow();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
